// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch addressing with stall, fetch
// handshake, and trap/jump redirects (trap has priority) with alignment checks.
module pc_gen #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned           PC_STEP      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  trap_en_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  input  logic                  fetch_ack_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  ce_o,
  output logic                  flush_o,
  output logic                  misalign_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(PC_STEP - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_pc_nxt;
  logic                    r_ce;
  logic                    w_ce_nxt;
  logic                    r_flush;
  logic                    w_flush_nxt;
  logic                    r_misalign;
  logic                    w_misalign_nxt;
  logic                    w_trap_mis;
  logic                    w_jump_mis;

  assign w_trap_mis = |(trap_vec_i & ALIGN_MASK);
  assign w_jump_mis = |(jump_addr_i & ALIGN_MASK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_pc       <= RESET_VECTOR;
      r_ce       <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ce       <= w_ce_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ce_nxt       = r_ce;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = RUN;
        w_pc_nxt    = RESET_VECTOR;
        w_ce_nxt    = 1'b1;
      end
      RUN: begin
        w_ce_nxt = !stall_i;
        if (trap_en_i) begin
          // Misaligned trap vectors are forced onto the fetch grid, not dropped.
          w_pc_nxt       = trap_vec_i & ~ALIGN_MASK;
          w_flush_nxt    = 1'b1;
          w_misalign_nxt = w_trap_mis;
        end else if (jump_en_i && !w_jump_mis) begin
          w_pc_nxt    = jump_addr_i;
          w_flush_nxt = 1'b1;
        end else begin
          w_misalign_nxt = jump_en_i;
          if (r_ce && fetch_ack_i && !stall_i)
            w_pc_nxt = r_pc + STEP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pc_o       = r_pc;
  assign ce_o       = r_ce;
  assign flush_o    = r_flush;
  assign misalign_o = r_misalign;

endmodule
